// File: rtl/multi_timer_if.sv
// Request/response bundle for multi_timer: per-channel controls in, status out.
// Lengths and elapsed counts are packed so channel i occupies bits [i*CNT_W +: CNT_W].
interface multi_timer_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 17
);
  logic [NUM_CH-1:0]            start;
  logic [NUM_CH-1:0]            stop;
  logic [NUM_CH-1:0]            periodic;
  logic [NUM_CH-1:0][CNT_W-1:0] length;
  logic [NUM_CH-1:0]            busy;
  logic [NUM_CH-1:0]            expired;
  logic [NUM_CH-1:0][CNT_W-1:0] elapsed;

  modport master (output start, stop, periodic, length, input busy, expired, elapsed);
  modport slave  (input start, stop, periodic, length, output busy, expired, elapsed);
endinterface

// File: rtl/multi_timer.sv
// Multi-channel tick timer: each channel has its own prescaler, latched length/mode,
// one-shot or auto-reload operation, cancel, and elapsed-tick readback.
module mt_chan #(
  parameter int CNT_W    = 17,
  parameter int TICK_DIV = 2025
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] length,
  output logic             busy,
  output logic             expired,
  output logic [CNT_W-1:0] elapsed
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TMAX = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           st, st_d;
  logic [PW-1:0]    presc, presc_d;
  logic [CNT_W-1:0] el_d, len_q, len_d, el_inc;
  logic             per_q, per_d, exp_d, tick;

  assign tick   = (presc == TMAX);
  assign el_inc = elapsed + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= IDLE;
      presc   <= '0;
      elapsed <= '0;
      len_q   <= '0;
      per_q   <= 1'b0;
      expired <= 1'b0;
    end else begin
      st      <= st_d;
      presc   <= presc_d;
      elapsed <= el_d;
      len_q   <= len_d;
      per_q   <= per_d;
      expired <= exp_d;
    end
  end

  // start > stop > expiry/tick; expired defaults low so every pulse lasts one cycle
  always_comb begin
    st_d    = st;
    presc_d = presc;
    el_d    = elapsed;
    len_d   = len_q;
    per_d   = per_q;
    exp_d   = 1'b0;
    if (start) begin
      len_d   = length;
      per_d   = periodic;
      presc_d = '0;
      el_d    = '0;
      st_d    = RUN;
    end else if (st == RUN) begin
      if (stop) begin
        st_d    = IDLE;
        presc_d = '0;
      end else begin
        presc_d = tick ? '0 : presc + PW'(1);
        if (len_q == '0) begin
          // zero length expires immediately; periodic repeats every cycle
          exp_d = 1'b1;
          if (!per_q) begin
            st_d    = IDLE;
            presc_d = '0;
          end
        end else if (tick) begin
          if (el_inc == len_q) begin
            exp_d = 1'b1;
            if (per_q) begin
              el_d = '0;
            end else begin
              el_d    = el_inc;
              st_d    = IDLE;
              presc_d = '0;
            end
          end else begin
            el_d = el_inc;
          end
        end
      end
    end
  end

  assign busy = (st == RUN);
endmodule

module multi_timer #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 17,
  parameter int TICK_DIV = 2025
) (
  input logic           clk,
  input logic           reset,
  multi_timer_if.slave  bus
);
  logic [NUM_CH-1:0]            busy_w, exp_w;
  logic [NUM_CH-1:0][CNT_W-1:0] el_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mt_chan #(.CNT_W(CNT_W), .TICK_DIV(TICK_DIV)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .start    (bus.start[i]),
      .stop     (bus.stop[i]),
      .periodic (bus.periodic[i]),
      .length   (bus.length[i]),
      .busy     (busy_w[i]),
      .expired  (exp_w[i]),
      .elapsed  (el_w[i])
    );
  end

  assign bus.busy    = busy_w;
  assign bus.expired = exp_w;
  assign bus.elapsed = el_w;
endmodule

// File: tb/tb_multi_timer.sv
// Directed, table-driven bench for multi_timer with NUM_CH=2, CNT_W=8, TICK_DIV=4.
module tb_multi_timer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  multi_timer_if #(.NUM_CH(2), .CNT_W(8)) bus ();

  multi_timer #(.NUM_CH(2), .CNT_W(8), .TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st, sp, per;
    logic [7:0] l0, l1;
    int         wt;
    logic [1:0] busy, exp;
    logic [7:0] e0, e1;
  } vec_t;

  vec_t v[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] b, input logic [1:0] x,
                         input logic [7:0] e0, input logic [7:0] e1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(b));
    chk({tag, "_exp"},  32'(bus.expired), 32'(x));
    chk({tag, "_el0"},  32'(bus.elapsed[0]), 32'(e0));
    chk({tag, "_el1"},  32'(bus.elapsed[1]), 32'(e1));
  endtask

  initial begin
    int stray;
    // st sp per l0 l1 wait | busy exp e0 e1 ; record drives one edge, then idles 'wait' edges
    // one-shot ch0 len3: pulse at k+12
    v.push_back('{2'b01, 2'b00, 2'b00, 8'd3, 8'd0, 0,  2'b01, 2'b00, 8'd0, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd3, 8'd0, 10, 2'b01, 2'b00, 8'd2, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd3, 8'd0, 0,  2'b00, 2'b01, 8'd3, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd3, 8'd0, 0,  2'b00, 2'b00, 8'd3, 8'd0});
    // periodic ch1 len2: pulses at k+8, k+16, k+24, then stop
    v.push_back('{2'b10, 2'b00, 2'b10, 8'd3, 8'd2, 0,  2'b10, 2'b00, 8'd3, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b10, 8'd3, 8'd2, 6,  2'b10, 2'b00, 8'd3, 8'd1});
    v.push_back('{2'b00, 2'b00, 2'b10, 8'd3, 8'd2, 0,  2'b10, 2'b10, 8'd3, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b10, 8'd3, 8'd2, 0,  2'b10, 2'b00, 8'd3, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b10, 8'd3, 8'd2, 6,  2'b10, 2'b10, 8'd3, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b10, 8'd3, 8'd2, 7,  2'b10, 2'b10, 8'd3, 8'd0});
    v.push_back('{2'b00, 2'b10, 2'b10, 8'd3, 8'd2, 0,  2'b00, 2'b00, 8'd3, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd3, 8'd2, 15, 2'b00, 2'b00, 8'd3, 8'd0});
    // ch0 len5 restarted at k+10 with len1: pulse at k+14 only
    v.push_back('{2'b01, 2'b00, 2'b00, 8'd5, 8'd0, 0,  2'b01, 2'b00, 8'd0, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd5, 8'd0, 8,  2'b01, 2'b00, 8'd2, 8'd0});
    v.push_back('{2'b01, 2'b00, 2'b00, 8'd1, 8'd0, 0,  2'b01, 2'b00, 8'd0, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 2,  2'b01, 2'b00, 8'd0, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 0,  2'b00, 2'b01, 8'd1, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd1, 8'd0, 6,  2'b00, 2'b00, 8'd1, 8'd0});
    // ch0 len2 stopped on its expiry edge k+8: no pulse, elapsed holds 1
    v.push_back('{2'b01, 2'b00, 2'b00, 8'd2, 8'd0, 0,  2'b01, 2'b00, 8'd0, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd2, 8'd0, 6,  2'b01, 2'b00, 8'd1, 8'd0});
    v.push_back('{2'b00, 2'b01, 2'b00, 8'd2, 8'd0, 0,  2'b00, 2'b00, 8'd1, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd2, 8'd0, 8,  2'b00, 2'b00, 8'd1, 8'd0});
    // ch0 one-shot len0: pulse at k+1
    v.push_back('{2'b01, 2'b00, 2'b00, 8'd0, 8'd0, 0,  2'b01, 2'b00, 8'd0, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 0,  2'b00, 2'b01, 8'd0, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 0,  2'b00, 2'b00, 8'd0, 8'd0});
    // ch1 periodic len0: pulse every cycle until stopped
    v.push_back('{2'b10, 2'b00, 2'b10, 8'd0, 8'd0, 0,  2'b10, 2'b00, 8'd0, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b10, 8'd0, 8'd0, 0,  2'b10, 2'b10, 8'd0, 8'd0});
    v.push_back('{2'b00, 2'b00, 2'b10, 8'd0, 8'd0, 0,  2'b10, 2'b10, 8'd0, 8'd0});
    v.push_back('{2'b00, 2'b10, 2'b10, 8'd0, 8'd0, 0,  2'b00, 2'b00, 8'd0, 8'd0});
    // stop while idle is ignored
    v.push_back('{2'b00, 2'b11, 2'b00, 8'd0, 8'd0, 2,  2'b00, 2'b00, 8'd0, 8'd0});

    reset        = 1'b1;
    bus.start    = '0;
    bus.stop     = '0;
    bus.periodic = '0;
    bus.length   = '0;
    step();
    step();
    chk_all("reset", 2'b00, 2'b00, 8'd0, 8'd0);
    reset = 1'b0;
    step();
    chk_all("post_reset", 2'b00, 2'b00, 8'd0, 8'd0);

    for (int i = 0; i < v.size(); i++) begin
      bus.start     = v[i].st;
      bus.stop      = v[i].sp;
      bus.periodic  = v[i].per;
      bus.length[0] = v[i].l0;
      bus.length[1] = v[i].l1;
      step();
      bus.start = '0;
      bus.stop  = '0;
      stray = 0;
      for (int j = 0; j < v[i].wt; j++) begin
        if (bus.expired !== 2'b00) stray++;
        step();
      end
      if (v[i].wt > 0) chk($sformatf("v%0d_stray", i), 32'(stray), 32'd0);
      chk_all($sformatf("v%0d", i), v[i].busy, v[i].exp, v[i].e0, v[i].e1);
    end

    // both channels started together, async reset lands mid-cycle after k+5
    bus.start     = 2'b11;
    bus.periodic  = 2'b00;
    bus.length[0] = 8'd1;
    bus.length[1] = 8'd3;
    step();
    bus.start = '0;
    stray = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 3 && bus.expired !== 2'b01) stray++;
      if (j != 3 && bus.expired !== 2'b00) stray++;
    end
    chk("both_pulses", 32'(stray), 32'd0);
    chk_all("pre_arst", 2'b10, 2'b00, 8'd1, 8'd1);
    #3;
    reset = 1'b1;
    #1;
    chk_all("arst_now", 2'b00, 2'b00, 8'd0, 8'd0);
    step();
    chk_all("arst_hold", 2'b00, 2'b00, 8'd0, 8'd0);
    reset = 1'b0;
    step();
    bus.start     = 2'b01;
    bus.length[0] = 8'd1;
    step();
    bus.start = '0;
    chk_all("fresh_start", 2'b01, 2'b00, 8'd0, 8'd0);
    stray = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      if (bus.expired !== 2'b00) stray++;
    end
    chk("fresh_early", 32'(stray), 32'd0);
    step();
    chk_all("fresh_exp", 2'b00, 2'b01, 8'd1, 8'd0);
    step();
    chk_all("fresh_after", 2'b00, 2'b00, 8'd1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
